mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle main-control state machine for the single-memory MIPS datapath. Each cycle it sequences the shared datapath by driving the 2:1 and 3:1 select lines (RegDst, MemtoReg, ALUSrcB, PCSource, IorD), the register, IR, PC and memory enables, and the ALU operation class. It handshakes with the unified instruction/data memory through a ready signal. It sits between the instruction register's opcode field and every select and enable input in the datapath.

## Interface
- No parameters; state and opcode encodings are fixed below.
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset
- Opcode  in  6  IR[31:26]
- MemReady  in  1  memory has completed the current read or write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA  out  1 each  datapath enables/selects
- RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource  out  2 each  mux selects / ALU class (00 add, 01 sub, 10 funct)
- Illegal  out  1  one-cycle pulse on unknown opcode
- State  out  4  current state, for debug

## Operation
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, JAL=12 (JAL only with the macro). Codes 13–15 are unreachable and map to FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite equal MemReady. The FSM stays in FETCH until MemReady=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 000000 goes to EXEC.
  - 100011 and 101011 go to MEMADR.
  - 000100 goes to BRANCH.
  - 000010 goes to JUMP.
  - 001000 goes to ADDIEX.
  - 000011 goes to JAL.
  - Any other opcode pulses Illegal=1 and goes to FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady=1, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: RegWrite=1, RegDst=01, MemtoReg=00. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=00, MemtoReg=00. Goes to FETCH.
- Any output not listed for a state is 0.
- Select code 11 is never driven on RegDst, MemtoReg or PCSource.

## Timing
- State is registered. Outputs are combinational from State, except IRWrite and PCWrite in FETCH, which are gated by MemReady.
- While Reset=0 at a clock edge, State becomes FETCH.
- While Reset=0, all outputs are forced to 0, including State. The forced 0 on State equals the FETCH encoding.
- Reset mid-operation (including during a memory wait) abandons the instruction. No enable is asserted in the reset cycle.
- The first FETCH outputs appear in the cycle after Reset returns high.
- Cycle counts with zero wait states (MemReady always 1):
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, jal 3.
  - Each low MemReady cycle in FETCH, MEMRD or MEMWR adds one cycle.
- During a wait, all outputs hold their state values and no write enables pulse.
- Illegal is high only in the DECODE cycle.

## Configuration
- Macro: MC_CTRL_JAL_EN.
- Defined:
  - Opcode 000011 goes DECODE → JAL.
  - JAL drives PCWrite=1, PCSource=10, RegWrite=1, RegDst=10 (r31), MemtoReg=10 (PC+4), then goes to FETCH.
- Undefined:
  - The JAL state does not exist.
  - Opcode 000011 is illegal: Illegal pulses in DECODE, then FETCH.
  - RegDst and MemtoReg never take the value 10.

## Test plan
- Reset low for 2 edges with Opcode=100011 and MemReady=1 → all outputs 0 and State=0; first cycle after release shows MemRead=1, ALUSrcB=01.
- R-type (000000), MemReady=1 → State sequence 0,1,6,7,0. In state 7: RegWrite=1, RegDst=01, MemtoReg=00.
- lw with MemReady low 3 cycles in MEMRD → State holds 3 for 3 cycles with MemRead=1, IorD=1. Then MEMWB: RegWrite=1, MemtoReg=01. Total 8 cycles.
- beq then j → beq gives PCWriteCond=1, ALUOp=01, PCSource=01 in state 8. j gives PCWrite=1, PCSource=10 in state 9. Each takes 3 cycles.
- Opcode 111111 → Illegal=1 for exactly the DECODE cycle, then State=0, with no RegWrite or MemWrite ever asserted.
- Opcode 000011 → with MC_CTRL_JAL_EN: State 12 with RegDst=10, MemtoReg=10, PCWrite=1. Without the macro: Illegal pulse.
- Reset asserted during a MEMWR wait → no MemWrite in the reset cycle, State=0 on the next edge.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle main-control FSM and the datapath.
// master: the control FSM (drives selects/enables, reads opcode and memory ready).
// slave:  the datapath/memory side.
interface mc_control_fsm_if;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Opcode, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ALUSrcA, RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource, Illegal, State
  );

  modport slave (
    output Opcode, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ALUSrcA, RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource, Illegal, State
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle main-control FSM for the single-memory MIPS datapath.
// State is registered; selects/enables decode combinationally from the state,
// with IRWrite/PCWrite in FETCH gated by MemReady and everything forced low
// while Reset is low.
// Optional feature macro: MC_CTRL_JAL_EN (adds the JAL state for opcode 000011).
module mc_control_fsm (
  input  logic              Clk,
  input  logic              Reset,
  mc_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11
`ifdef MC_CTRL_JAL_EN
    , ST_JAL  = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // DECODE dispatch; an unknown opcode falls back to FETCH, which also flags Illegal.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:     nxt = ST_EXEC;
      OP_LW, OP_SW: nxt = ST_MEMADR;
      OP_BEQ:       nxt = ST_BRANCH;
      OP_J:         nxt = ST_JUMP;
      OP_ADDI:      nxt = ST_ADDIEX;
`ifdef MC_CTRL_JAL_EN
      OP_JAL:       nxt = ST_JAL;
`endif
      default:      nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

  state_t     state_r;

  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic       iord_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] reg_dst_s;
  logic [1:0] memto_reg_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic [1:0] pc_source_s;
  logic       illegal_s;
  logic [3:0] state_out_s;

  // State register and transitions; memory states hold until MemReady.
  always_ff @(posedge Clk) begin
    if (Reset == 1'b0) begin
      state_r <= ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH:  state_r <= bus.MemReady ? ST_DECODE : ST_FETCH;
        ST_DECODE: state_r <= decode_next(bus.Opcode);
        ST_MEMADR: state_r <= (bus.Opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
        ST_MEMRD:  state_r <= bus.MemReady ? ST_MEMWB : ST_MEMRD;
        ST_MEMWB:  state_r <= ST_FETCH;
        ST_MEMWR:  state_r <= bus.MemReady ? ST_FETCH : ST_MEMWR;
        ST_EXEC:   state_r <= ST_ALUWB;
        ST_ALUWB:  state_r <= ST_FETCH;
        ST_BRANCH: state_r <= ST_FETCH;
        ST_JUMP:   state_r <= ST_FETCH;
        ST_ADDIEX: state_r <= ST_ADDIWB;
        ST_ADDIWB: state_r <= ST_FETCH;
`ifdef MC_CTRL_JAL_EN
        ST_JAL:    state_r <= ST_FETCH;
`endif
        default:   state_r <= ST_FETCH;
      endcase
    end
  end

  // Per-state control decode; all outputs low while Reset is held low.
  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    iord_s          = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    reg_dst_s       = 2'b00;
    memto_reg_s     = 2'b00;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    pc_source_s     = 2'b00;
    illegal_s       = 1'b0;
    state_out_s     = 4'd0;
    if (Reset == 1'b0) begin
      state_out_s = 4'd0;
    end else begin
      state_out_s = state_r;
      case (state_r)
        ST_FETCH: begin
          mem_read_s  = 1'b1;
          alu_src_b_s = 2'b01;
          ir_write_s  = bus.MemReady;
          pc_write_s  = bus.MemReady;
        end
        ST_DECODE: begin
          alu_src_b_s = 2'b11;
          illegal_s   = (decode_next(bus.Opcode) == ST_FETCH);
        end
        ST_MEMADR, ST_ADDIEX: begin
          alu_src_a_s = 1'b1;
          alu_src_b_s = 2'b10;
        end
        ST_MEMRD: begin
          mem_read_s = 1'b1;
          iord_s     = 1'b1;
        end
        ST_MEMWB: begin
          reg_write_s = 1'b1;
          memto_reg_s = 2'b01;
        end
        ST_MEMWR: begin
          mem_write_s = 1'b1;
          iord_s      = 1'b1;
        end
        ST_EXEC: begin
          alu_src_a_s = 1'b1;
          alu_op_s    = 2'b10;
        end
        ST_ALUWB: begin
          reg_write_s = 1'b1;
          reg_dst_s   = 2'b01;
        end
        ST_BRANCH: begin
          alu_src_a_s     = 1'b1;
          alu_op_s        = 2'b01;
          pc_write_cond_s = 1'b1;
          pc_source_s     = 2'b01;
        end
        ST_JUMP: begin
          pc_write_s  = 1'b1;
          pc_source_s = 2'b10;
        end
        ST_ADDIWB: begin
          reg_write_s = 1'b1;
        end
`ifdef MC_CTRL_JAL_EN
        ST_JAL: begin
          pc_write_s  = 1'b1;
          pc_source_s = 2'b10;
          reg_write_s = 1'b1;
          reg_dst_s   = 2'b10;
          memto_reg_s = 2'b10;
        end
`endif
        default: begin
          state_out_s = state_r;
        end
      endcase
    end
  end

  assign bus.PCWrite     = pc_write_s;
  assign bus.PCWriteCond = pc_write_cond_s;
  assign bus.IorD        = iord_s;
  assign bus.MemRead     = mem_read_s;
  assign bus.MemWrite    = mem_write_s;
  assign bus.IRWrite     = ir_write_s;
  assign bus.RegWrite    = reg_write_s;
  assign bus.ALUSrcA     = alu_src_a_s;
  assign bus.RegDst      = reg_dst_s;
  assign bus.MemtoReg    = memto_reg_s;
  assign bus.ALUSrcB     = alu_src_b_s;
  assign bus.ALUOp       = alu_op_s;
  assign bus.PCSource    = pc_source_s;
  assign bus.Illegal     = illegal_s;
  assign bus.State       = state_out_s;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench for mc_control_fsm. Expected control words are
// hand-written per state; field order of a control word:
// {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,ALUSrcA,
//  RegDst[1:0],MemtoReg[1:0],ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],Illegal}
module tb_mc_control_fsm;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_fail;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  localparam logic [18:0] E_ZERO     = 19'd0;
  localparam logic [18:0] E_FETCH    = {8'b1001_0100, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_FETCH_W  = {8'b0001_0000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_DECODE   = {8'b0000_0000, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_DEC_ILL  = {8'b0000_0000, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [18:0] E_MEMADR   = {8'b0000_0001, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_MEMRD    = {8'b0011_0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_MEMWB    = {8'b0000_0010, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_MEMWR    = {8'b0010_1000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_EXEC     = {8'b0000_0001, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [18:0] E_ALUWB    = {8'b0000_0010, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_BRANCH   = {8'b0100_0001, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [18:0] E_JUMP     = {8'b1000_0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [18:0] E_ADDIEX   = {8'b0000_0001, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_ADDIWB   = {8'b0000_0010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_JAL      = {8'b1000_0010, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0};

  // Snapshot of every control output as one word.
  function automatic logic [18:0] ctl_now();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.RegWrite, bus.ALUSrcA, bus.RegDst, bus.MemtoReg,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.Illegal};
  endfunction

  // Single comparison point: counts every check, reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: after the edge, apply this cycle's inputs, then check state and controls.
  task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                     input logic mr, input logic [3:0] es, input logic [18:0] ec);
    @(posedge Clk);
    #1;
    Reset        = rst;
    bus.Opcode   = op;
    bus.MemReady = mr;
    #1;
    check_eq({tag, "/state"}, 32'(bus.State), 32'(es));
    check_eq({tag, "/ctl"}, 32'(ctl_now()), 32'(ec));
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    Reset        = 1'b0;
    bus.Opcode   = OP_LW;
    bus.MemReady = 1'b1;

    // Reset held low across two edges
    cyc("rst0", 1'b0, OP_LW, 1'b1, 4'd0, E_ZERO);
    cyc("rst1", 1'b0, OP_LW, 1'b1, 4'd0, E_ZERO);

    // lw, 3 wait cycles in MEMRD: 8 cycles total
    cyc("lw_fetch",  1'b1, OP_LW, 1'b1, 4'd0, E_FETCH);
    cyc("lw_decode", 1'b1, OP_LW, 1'b1, 4'd1, E_DECODE);
    cyc("lw_memadr", 1'b1, OP_LW, 1'b1, 4'd2, E_MEMADR);
    cyc("lw_wait1",  1'b1, OP_LW, 1'b0, 4'd3, E_MEMRD);
    cyc("lw_wait2",  1'b1, OP_LW, 1'b0, 4'd3, E_MEMRD);
    cyc("lw_wait3",  1'b1, OP_LW, 1'b0, 4'd3, E_MEMRD);
    cyc("lw_memrd",  1'b1, OP_LW, 1'b1, 4'd3, E_MEMRD);
    cyc("lw_memwb",  1'b1, OP_LW, 1'b1, 4'd4, E_MEMWB);

    // R-type: 0,1,6,7
    cyc("r_fetch",  1'b1, OP_R, 1'b1, 4'd0, E_FETCH);
    cyc("r_decode", 1'b1, OP_R, 1'b1, 4'd1, E_DECODE);
    cyc("r_exec",   1'b1, OP_R, 1'b1, 4'd6, E_EXEC);
    cyc("r_aluwb",  1'b1, OP_R, 1'b1, 4'd7, E_ALUWB);

    // beq then j, 3 cycles each
    cyc("beq_fetch",  1'b1, OP_BEQ, 1'b1, 4'd0, E_FETCH);
    cyc("beq_decode", 1'b1, OP_BEQ, 1'b1, 4'd1, E_DECODE);
    cyc("beq_branch", 1'b1, OP_BEQ, 1'b1, 4'd8, E_BRANCH);
    cyc("j_fetch",    1'b1, OP_J,   1'b1, 4'd0, E_FETCH);
    cyc("j_decode",   1'b1, OP_J,   1'b1, 4'd1, E_DECODE);
    cyc("j_jump",     1'b1, OP_J,   1'b1, 4'd9, E_JUMP);

    // sw with one wait in FETCH
    cyc("sw_fwait",  1'b1, OP_SW, 1'b0, 4'd0, E_FETCH_W);
    cyc("sw_fetch",  1'b1, OP_SW, 1'b1, 4'd0, E_FETCH);
    cyc("sw_decode", 1'b1, OP_SW, 1'b1, 4'd1, E_DECODE);
    cyc("sw_memadr", 1'b1, OP_SW, 1'b1, 4'd2, E_MEMADR);
    cyc("sw_memwr",  1'b1, OP_SW, 1'b1, 4'd5, E_MEMWR);

    // addi: 0,1,10,11
    cyc("addi_fetch",  1'b1, OP_ADDI, 1'b1, 4'd0,  E_FETCH);
    cyc("addi_decode", 1'b1, OP_ADDI, 1'b1, 4'd1,  E_DECODE);
    cyc("addi_ex",     1'b1, OP_ADDI, 1'b1, 4'd10, E_ADDIEX);
    cyc("addi_wb",     1'b1, OP_ADDI, 1'b1, 4'd11, E_ADDIWB);

    // Unknown opcode: Illegal only in DECODE, back to FETCH
    cyc("bad_fetch",  1'b1, OP_BAD, 1'b1, 4'd0, E_FETCH);
    cyc("bad_decode", 1'b1, OP_BAD, 1'b1, 4'd1, E_DEC_ILL);

    // jal: own state with the macro, illegal without
    cyc("jal_fetch",  1'b1, OP_JAL, 1'b1, 4'd0, E_FETCH);
`ifdef MC_CTRL_JAL_EN
    cyc("jal_decode", 1'b1, OP_JAL, 1'b1, 4'd1,  E_DECODE);
    cyc("jal_jal",    1'b1, OP_JAL, 1'b1, 4'd12, E_JAL);
`else
    cyc("jal_decode", 1'b1, OP_JAL, 1'b1, 4'd1, E_DEC_ILL);
`endif

    // Reset during a MEMWR wait abandons the store
    cyc("swr_fetch",  1'b1, OP_SW, 1'b1, 4'd0, E_FETCH);
    cyc("swr_decode", 1'b1, OP_SW, 1'b1, 4'd1, E_DECODE);
    cyc("swr_memadr", 1'b1, OP_SW, 1'b1, 4'd2, E_MEMADR);
    cyc("swr_wait",   1'b1, OP_SW, 1'b0, 4'd5, E_MEMWR);
    cyc("swr_reset",  1'b0, OP_SW, 1'b0, 4'd0, E_ZERO);
    cyc("swr_after",  1'b1, OP_SW, 1'b1, 4'd0, E_FETCH);
    cyc("swr_next",   1'b1, OP_SW, 1'b1, 4'd1, E_DECODE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
